// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the width of the state register.
package serial_subtractor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The bit counter must hold values up to WIDTH-1, with one spare bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake bundle between a producer, the serial subtractor and a consumer.
//  in_valid/in_ready  : operand handshake (a, b, bin)
//  out_valid/out_ready: result handshake (d, bout)
// Modports:
//  master - producer/consumer side (drives operands and out_ready)
//  slave  - subtractor side
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell, gate level, purely combinational.
//  diff = a ^ b ^ bin
//  bout = borrow out of (a - b - bin)
// Ports: diff/bout outputs, a/b/bin inputs (all 1 bit).
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);
  logic a_x_b;

  assign a_x_b = a ^ b;
  assign diff  = a_x_b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout  = (~a & b) | (~a_x_b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B - Bin, LSB first over WIDTH cycles
// through a single full-subtractor cell and one borrow flop.
// Ports:
//  clk   - rising-edge clock
//  rst_n - asynchronous active-low reset
//  bus   - slave side of serial_subtractor_if (operand and result handshakes)
// Flow: IDLE accepts operands, SHIFT runs WIDTH cycles, DONE presents the
// result until the consumer takes it, then one mandatory IDLE cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cell_diff;
  logic             cell_bout;

  // The operand LSBs and the running borrow feed the one shared cell.
  full_subtractor u_fs (
    .diff (cell_diff),
    .bout (cell_bout),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Difference bits enter at the MSB so after WIDTH shifts bit 0 is in place.
        d_d   = {cell_diff, d_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bout_d  = cell_bout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: table of WIDTH=4 vectors, hand-written
// backpressure and mid-operation reset sequences, plus a WIDTH=8 random run
// against the {bout,d} = {0,a} - {0,b} - bin reference.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n),  .bus(bus4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

  int n_tests = 0;
  int n_fail  = 0;
  bit done8   = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_d;
    logic       exp_bout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at a negedge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] ed, input logic eb, input string nm,
                        input bit release_res);
    int lat;
    bit busy_bad;
    chk({nm, " in_ready idle"}, 32'(bus4.in_ready), 32'd1);
    bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.a = ~a; bus4.b = ~b; bus4.bin = ~bin;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus4.out_valid && lat < 40) begin
      if (bus4.in_ready) busy_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, " in_ready low while busy"}, 32'(busy_bad), 32'd0);
    chk({nm, " latency"}, 32'(lat), 32'd4);
    chk({nm, " d"}, 32'(bus4.d), 32'(ed));
    chk({nm, " bout"}, 32'(bus4.bout), 32'(eb));
    if (release_res) begin
      bus4.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus4.out_ready = 1'b0;
      chk({nm, " back to idle"}, {30'd0, bus4.in_ready, bus4.out_valid}, 32'b10);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // WIDTH=4 directed tests
  initial begin
    vec_t vecs[9];
    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    vecs[5] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1};
    vecs[6] = '{4'h8, 4'h7, 1'b1, 4'h0, 1'b0};
    vecs[7] = '{4'h5, 4'h5, 1'b1, 4'hF, 1'b1};
    vecs[8] = '{4'hA, 4'h3, 1'b1, 4'h6, 1'b0};

    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0; bus4.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {25'd0, bus4.in_ready, bus4.out_valid, bus4.bout, bus4.d},
        {25'd0, 1'b1, 1'b0, 1'b0, 4'h0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_d, vecs[i].exp_bout,
             $sformatf("vec%0d", i), 1'b1);

    // Backpressure: result must hold while new operands are offered and ignored.
    run_op(4'hC, 4'h4, 1'b0, 4'h8, 1'b0, "bp", 1'b0);
    for (int c = 0; c < 10; c++) begin
      bus4.in_valid = c[0];
      bus4.a = 4'h1; bus4.b = 4'h2; bus4.bin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp hold%0d", c),
          {26'd0, bus4.out_valid, bus4.in_ready, bus4.bout, bus4.d}, {26'd0, 1'b1, 1'b0, 1'b0, 4'h8});
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    chk("bp release", {26'd0, bus4.out_valid, bus4.in_ready, bus4.bout, bus4.d},
        {26'd0, 1'b0, 1'b1, 1'b0, 4'h8});
    run_op(4'h7, 4'h2, 1'b1, 4'h4, 1'b0, "after bp", 1'b1);

    // Reset two cycles into SHIFT aborts the operation immediately.
    bus4.a = 4'hF; bus4.b = 4'h1; bus4.bin = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset", {25'd0, bus4.in_ready, bus4.out_valid, bus4.bout, bus4.d},
        {25'd0, 1'b1, 1'b0, 1'b0, 4'h0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", {30'd0, bus4.in_ready, bus4.out_valid}, 32'b10);
    run_op(4'h5, 4'h2, 1'b0, 4'h3, 1'b0, "after reset", 1'b1);

    wait (done8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // WIDTH=8 random operations with random input and output gaps
  initial begin
    logic [7:0] ra, rb;
    logic       rbin;
    logic [8:0] exp9;
    int         lat;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b0;
    rst8_n = 1'b0;
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus8.a = ra; bus8.b = rb; bus8.bin = rbin; bus8.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      lat = 0;
      while (!bus8.out_valid && lat < 40) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk($sformatf("w8 op%0d latency", i), 32'(lat), 32'd8);
      exp9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      chk($sformatf("w8 op%0d {bout,d}", i), 32'({bus8.bout, bus8.d}), 32'(exp9));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus8.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.out_ready = 1'b0;
    end
    done8 = 1'b1;
  end

endmodule
